// File: rtl/div_pkg.sv
// Shared constants, state encoding and the prefix-cell helper for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 19;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  // Generate-combine cell shared with the adder trees: g_hi | (p_hi & g_lo).
  function automatic logic a_or_bc(input logic a, input logic b, input logic c);
    return a | (b & c);
  endfunction

endpackage

// File: rtl/brentkung_subtractor_20bits.sv
// Brent-Kung prefix subtractor: diff = a - b computed as a + ~b + 1.
// carry_out = 1 means no borrow (a >= b).
module brentkung_subtractor_20bits
  import div_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         carry_out
);

  localparam int LVL = $clog2(N);

  logic [N-1:0] p_bit;
  logic [N-1:0] g_bit;
  logic [N-1:0] g_v;
  logic [N-1:0] p_v;

  assign p_bit = a ^ ~b;
  assign g_bit = a & ~b;

  always_comb begin
    g_v = g_bit;
    p_v = p_bit;
    // Carry-in of 1 is folded into bit 0, so every prefix G[i:0] already includes it.
    g_v[0] = a_or_bc(g_bit[0], p_bit[0], 1'b1);
    for (int l = 0; l < LVL; l++) begin
      for (int i = (2 << l) - 1; i < N; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          g_v[i] = a_or_bc(g_v[i], p_v[i], g_v[i - (1 << l)]);
          p_v[i] = p_v[i] & p_v[i - (1 << l)];
        end
      end
    end
    for (int l = LVL - 1; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < N; i++) begin
        if (((i + 1) % (2 << l)) == (1 << l)) begin
          g_v[i] = a_or_bc(g_v[i], p_v[i], g_v[i - (1 << l)]);
        end
      end
    end
  end

  assign diff      = p_bit ^ {g_v[N-2:0], 1'b1};
  assign carry_out = g_v[N-1];

endmodule

// File: rtl/seq_divider_unsigned_19bits.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (adds one negation cycle).
module seq_divider_unsigned_19bits
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_next;
  logic             no_borrow;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             unused_prem_msb;

  // The dividend register shifts out its MSB each step and the quotient bit shifts in.
  assign shifted         = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
  assign prem_next       = no_borrow ? trial : shifted;
  assign unused_prem_msb = prem_q[WIDTH];

  brentkung_subtractor_20bits #(
    .N(WIDTH + 1)
  ) u_sub (
    .a        (shifted),
    .b        ({1'b0, dvs_q}),
    .diff     (trial),
    .carry_out(no_borrow)
  );

`ifdef DIV_SIGNED_EN
  logic neg_pend_q, neg_pend_d;
  logic quot_neg_q, quot_neg_d;
  logic rem_neg_q, rem_neg_d;

  assign dvd_mag   = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag   = divisor[WIDTH-1] ? -divisor : divisor;
  assign out_valid = (state_q == DONE) && !neg_pend_q;
`else
  assign dvd_mag   = dividend;
  assign dvs_mag   = divisor;
  assign out_valid = (state_q == DONE);
`endif

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_pend_d = neg_pend_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d  = '0;
          prem_d = '0;
`ifdef DIV_SIGNED_EN
          neg_pend_d = 1'b0;
          quot_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rem_neg_d  = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DIV_ZERO_QUOT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            work_d  = dvd_mag;
            dvs_d   = dvs_mag;
          end
        end
      end
      CALC: begin
        prem_d = prem_next;
        work_d = {work_q[WIDTH-2:0], no_borrow};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          quot_d  = {work_q[WIDTH-2:0], no_borrow};
          rem_d   = prem_next[WIDTH-1:0];
          dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
          neg_pend_d = 1'b1;
`endif
        end
      end
      DONE: begin
`ifdef DIV_SIGNED_EN
        // Sign fix-up cycle: truncating quotient, remainder follows the dividend.
        if (neg_pend_q) begin
          neg_pend_d = 1'b0;
          quot_d     = quot_neg_q ? -quot_q : quot_q;
          rem_d      = rem_neg_q ? -rem_q : rem_q;
        end else if (out_ready) begin
          state_d = IDLE;
        end
`else
        if (out_ready) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_pend_q <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      neg_pend_q <= neg_pend_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_divider_unsigned_19bits.sv
// Self-checking bench for seq_divider_unsigned_19bits: vector table, handshake corners, random vs. model.
module tb_seq_divider_unsigned_19bits;

  localparam int W = 19;
  localparam logic [W-1:0] MASK = '1;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  always #5 clk = ~clk;

  seq_divider_unsigned_19bits dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    if (b == '0) begin
      q   = MASK;
      r   = a;
      dbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa  = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb  = b[W-1] ? int'(b) - (1 << W) : int'(b);
      q   = W'(sa / sb);
      r   = W'(sa % sb);
`else
      q   = a / b;
      r   = a % b;
`endif
      dbz = 1'b0;
    end
  endtask

  // Entered and left at posedge+1. Cycle 0 is the cycle in_valid is presented.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz,
                       output int lat, output logic flow_ok);
    int guard;
    flow_ok = 1'b1;
    lat     = -1;
    guard   = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) flow_ok = 1'b0;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
  endtask

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] q, r, eq, er, a, b;
    logic         dbz, edbz, flow, hold_ok, seen;
    int           lat, sel;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

`ifdef DIV_SIGNED_EN
    vecs.push_back('{19'h7FFF9, 19'd2,      19'h7FFFD, 19'h7FFFF, 1'b0, LAT});
    vecs.push_back('{19'd7,     19'h7FFFE,  19'h7FFFD, 19'd1,     1'b0, LAT});
    vecs.push_back('{19'h40000, 19'h7FFFF,  19'h40000, 19'd0,     1'b0, LAT});
    vecs.push_back('{19'd12345, 19'd0,      19'h7FFFF, 19'd12345, 1'b1, 1});
    vecs.push_back('{19'd100,   19'd7,      19'd14,    19'd2,     1'b0, LAT});
    vecs.push_back('{19'h7FF9C, 19'h7FFF9,  19'd14,    19'h7FFFE, 1'b0, LAT});
    vecs.push_back('{19'h7FFFF, 19'd1,      19'h7FFFF, 19'd0,     1'b0, LAT});
`else
    vecs.push_back('{19'd100,    19'd7,      19'd14,     19'd2,     1'b0, LAT});
    vecs.push_back('{19'd524287, 19'd1,      19'h7FFFF,  19'd0,     1'b0, LAT});
    vecs.push_back('{19'd5,      19'd524287, 19'd0,      19'd5,     1'b0, LAT});
    vecs.push_back('{19'd12345,  19'd0,      19'h7FFFF,  19'd12345, 1'b1, 1});
    vecs.push_back('{19'd0,      19'd5,      19'd0,      19'd0,     1'b0, LAT});
    vecs.push_back('{19'd524287, 19'd524287, 19'd1,      19'd0,     1'b0, LAT});
    vecs.push_back('{19'd262144, 19'd3,      19'd87381,  19'd1,     1'b0, LAT});
    vecs.push_back('{19'd524287, 19'd2,      19'd262143, 19'd1,     1'b0, LAT});
`endif

    foreach (vecs[k]) begin
      do_op(vecs[k].a, vecs[k].b, q, r, dbz, lat, flow);
      check($sformatf("vec%0d_quot", k), q, vecs[k].q);
      check($sformatf("vec%0d_rem", k), r, vecs[k].r);
      check($sformatf("vec%0d_dbz", k), dbz, vecs[k].dbz);
      check($sformatf("vec%0d_lat", k), lat, vecs[k].lat);
      check($sformatf("vec%0d_busy_flow", k), flow, 1);
      @(posedge clk);
      #1;
    end

    // Backpressure: result must hold and a pending request must not be taken.
    out_ready = 1'b0;
    do_op(19'd1000, 19'd3, q, r, dbz, lat, flow);
    check("bp_lat", lat, LAT);
    dividend = 19'd7;
    divisor  = 19'd7;
    in_valid = 1'b1;
    hold_ok  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 19'd333 ||
          remainder !== 19'd1 || div_by_zero !== 1'b0) hold_ok = 1'b0;
    end
    check("bp_hold", hold_ok, 1);
    check("bp_quot", quotient, 333);
    check("bp_rem", remainder, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);
    check("bp_release_quot_held", quotient, 333);

    // Synchronous reset at cycle 8 of an operation aborts it.
    dividend = 19'd400000;
    divisor  = 19'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_quot", quotient, 0);
    check("abort_rem", remainder, 0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    do_op(19'd81, 19'd9, q, r, dbz, lat, flow);
    check("after_abort_quot", q, 9);
    check("after_abort_rem", r, 0);
    check("after_abort_lat", lat, LAT);
    @(posedge clk);
    #1;

    // Random operands against the integer model.
    for (int k = 0; k < 2000; k++) begin
      a   = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel < 5) b = W'($urandom_range(1, 64));
      else b = W'($urandom);
      if (sel < 5 && $urandom_range(0, 3) == 0) b = MASK - b + 1'b1;
      model(a, b, eq, er, edbz);
      do_op(a, b, q, r, dbz, lat, flow);
      check($sformatf("rand_quot a=%0h b=%0h", a, b), q, eq);
      check($sformatf("rand_rem a=%0h b=%0h", a, b), r, er);
      check($sformatf("rand_dbz a=%0h b=%0h", a, b), dbz, edbz);
      check($sformatf("rand_lat a=%0h b=%0h", a, b), lat, edbz ? 1 : LAT);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
